// File: rtl/imem_load_ctrl.sv
// Instruction-memory port sequencer: arbitrates fetch reads against program-loader writes.
// Optional post-reset zero fill of the RAM is compiled in with IMEM_CLEAR_ON_RESET_EN.
module imem_load_ctrl #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          fetch_req,
  input  logic [31:0]   fetch_addr,
  output logic [31:0]   fetch_data,
  output logic          fetch_valid,
  output logic          cpu_stall,
  input  logic          load_start,
  input  logic          load_valid,
  input  logic          load_last,
  input  logic [31:0]   load_data,
  output logic          load_ready,
  output logic          load_done,
  output logic          load_err,
  output logic [AW:0]   load_count,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_LOAD  = 2'd1
`ifdef IMEM_CLEAR_ON_RESET_EN
    , ST_CLEAR = 2'd2
`endif
  } state_t;

`ifdef IMEM_CLEAR_ON_RESET_EN
  localparam state_t          RESET_STATE = ST_CLEAR;
  localparam logic            RESET_STALL = 1'b1;
  localparam logic [AW-1:0]   LAST_IDX    = AW'(DEPTH - 1);
`else
  localparam state_t          RESET_STATE = ST_RUN;
  localparam logic            RESET_STALL = 1'b0;
`endif
  localparam logic [AW:0]     DEPTH_CNT   = (AW + 1)'(DEPTH);

  state_t        state_q, state_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW:0]   load_count_q, load_count_d;
  logic          load_err_q, load_err_d;
  logic          load_done_q, load_done_d;
  logic          load_ready_q, load_ready_d;
  logic          fetch_valid_q, fetch_valid_d;
  logic          cpu_stall_q, cpu_stall_d;
  logic [AW-1:0] addr_hold_q, addr_hold_d;
`ifdef IMEM_CLEAR_ON_RESET_EN
  logic [AW-1:0] clr_idx_q, clr_idx_d;
`endif

  logic          handshake_s;
  logic          full_s;
  logic          mem_we_s;
  logic [AW-1:0] mem_addr_s;
  logic [31:0]   mem_wdata_s;
  logic          unused_fetch_bits_s;

  assign unused_fetch_bits_s = &{1'b0, fetch_addr[31:AW+2], fetch_addr[1:0]};
  assign handshake_s = load_ready_q & load_valid;
  assign full_s      = (load_count_q == DEPTH_CNT);

  // Next-state, pointer, counter and status computation
  always_comb begin
    state_d      = state_q;
    wptr_d       = wptr_q;
    load_count_d = load_count_q;
    load_err_d   = load_err_q;
    load_done_d  = 1'b0;
`ifdef IMEM_CLEAR_ON_RESET_EN
    clr_idx_d    = clr_idx_q;
`endif
    case (state_q)
      ST_RUN: begin
        if (load_start) begin
          state_d      = ST_LOAD;
          wptr_d       = '0;
          load_count_d = '0;
          load_err_d   = 1'b0;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_LOAD: begin
        if (handshake_s) begin
          // Past DEPTH words the data is consumed but never written.
          if (full_s) begin
            load_err_d = 1'b1;
          end else begin
            wptr_d       = wptr_q + AW'(1);
            load_count_d = load_count_q + (AW + 1)'(1);
          end
          if (load_last) begin
            state_d     = ST_RUN;
            load_done_d = 1'b1;
          end else begin
            state_d = ST_LOAD;
          end
        end else begin
          state_d = ST_LOAD;
        end
      end
`ifdef IMEM_CLEAR_ON_RESET_EN
      ST_CLEAR: begin
        clr_idx_d = clr_idx_q + AW'(1);
        if (clr_idx_q == LAST_IDX) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_CLEAR;
        end
      end
`endif
      default: begin
        state_d = ST_RUN;
      end
    endcase
    fetch_valid_d = (state_q == ST_RUN) && fetch_req;
    cpu_stall_d   = (state_d != ST_RUN);
    load_ready_d  = (state_d == ST_LOAD);
  end

  // RAM port mux; forced idle while reset is asserted so it reads as reset values
  always_comb begin
    mem_we_s    = 1'b0;
    mem_addr_s  = addr_hold_q;
    mem_wdata_s = '0;
    if (rst) begin
      mem_addr_s = '0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (fetch_req) begin
            mem_addr_s = fetch_addr[AW+1:2];
          end else begin
            mem_addr_s = addr_hold_q;
          end
        end
        ST_LOAD: begin
          if (handshake_s) begin
            mem_addr_s  = wptr_q;
            mem_we_s    = ~full_s;
            mem_wdata_s = full_s ? 32'h0000_0000 : load_data;
          end else begin
            mem_addr_s = addr_hold_q;
          end
        end
`ifdef IMEM_CLEAR_ON_RESET_EN
        ST_CLEAR: begin
          mem_we_s   = 1'b1;
          mem_addr_s = clr_idx_q;
        end
`endif
        default: begin
          mem_addr_s = addr_hold_q;
        end
      endcase
    end
    addr_hold_d = mem_addr_s;
  end

  // State and registered-output flops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= RESET_STATE;
      wptr_q        <= '0;
      load_count_q  <= '0;
      load_err_q    <= 1'b0;
      load_done_q   <= 1'b0;
      load_ready_q  <= 1'b0;
      fetch_valid_q <= 1'b0;
      cpu_stall_q   <= RESET_STALL;
      addr_hold_q   <= '0;
`ifdef IMEM_CLEAR_ON_RESET_EN
      clr_idx_q     <= '0;
`endif
    end else begin
      state_q       <= state_d;
      wptr_q        <= wptr_d;
      load_count_q  <= load_count_d;
      load_err_q    <= load_err_d;
      load_done_q   <= load_done_d;
      load_ready_q  <= load_ready_d;
      fetch_valid_q <= fetch_valid_d;
      cpu_stall_q   <= cpu_stall_d;
      addr_hold_q   <= addr_hold_d;
`ifdef IMEM_CLEAR_ON_RESET_EN
      clr_idx_q     <= clr_idx_d;
`endif
    end
  end

  assign fetch_data  = mem_rdata;
  assign fetch_valid = fetch_valid_q;
  assign cpu_stall   = cpu_stall_q;
  assign load_ready  = load_ready_q;
  assign load_done   = load_done_q;
  assign load_err    = load_err_q;
  assign load_count  = load_count_q;
  assign mem_addr    = mem_addr_s;
  assign mem_we      = mem_we_s;
  assign mem_wdata   = mem_wdata_s;

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Bench for imem_load_ctrl: behavioural RAM, expected-contents array built from the stimulus,
// randomized load/fetch traffic and the directed corner cases.
module tb_imem_load_ctrl;
  localparam int DEPTH = 256;
  localparam int AW    = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          fetch_req;
  logic [31:0]   fetch_addr;
  logic [31:0]   fetch_data;
  logic          fetch_valid;
  logic          cpu_stall;
  logic          load_start;
  logic          load_valid;
  logic          load_last;
  logic [31:0]   load_data;
  logic          load_ready;
  logic          load_done;
  logic          load_err;
  logic [AW:0]   load_count;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;

  logic [31:0] ram [DEPTH];
  logic [31:0] ref_mem [DEPTH];
  logic [31:0] ld_words [$];
  int vectors = 0;
  int miscompares = 0;
`ifdef IMEM_CLEAR_ON_RESET_EN
  localparam logic EXP_RST_STALL = 1'b1;
`else
  localparam logic EXP_RST_STALL = 1'b0;
`endif

  always #5 clk = ~clk;

  imem_load_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_data(fetch_data),
    .fetch_valid(fetch_valid), .cpu_stall(cpu_stall),
    .load_start(load_start), .load_valid(load_valid), .load_last(load_last),
    .load_data(load_data), .load_ready(load_ready), .load_done(load_done),
    .load_err(load_err), .load_count(load_count),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // synchronous-read single-port RAM
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) % DEPTH);
  endfunction

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_stall"}, 64'(cpu_stall), 64'(EXP_RST_STALL));
    chk({tag, "_fvalid"}, 64'(fetch_valid), 64'd0);
    chk({tag, "_ready"}, 64'(load_ready), 64'd0);
    chk({tag, "_done"}, 64'(load_done), 64'd0);
    chk({tag, "_err"}, 64'(load_err), 64'd0);
    chk({tag, "_we"}, 64'(mem_we), 64'd0);
    chk({tag, "_count"}, 64'(load_count), 64'd0);
    chk({tag, "_addr"}, 64'(mem_addr), 64'd0);
  endtask

  task automatic wait_clear();
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      if (i == 0 || i == DEPTH - 1 || (i % 37) == 5) begin
        chk("clr_we", 64'(mem_we), 64'd1);
        chk("clr_addr", 64'(mem_addr), 64'(i));
        chk("clr_wdata", 64'(mem_wdata), 64'd0);
        chk("clr_stall", 64'(cpu_stall), 64'd1);
      end
      step();
    end
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'h0;
  endtask

  task automatic do_fetch(input logic [31:0] a);
    fetch_req  = 1'b1;
    fetch_addr = a;
    @(negedge clk);
    chk("fetch_addr", 64'(mem_addr), 64'(widx(a)));
    chk("fetch_we", 64'(mem_we), 64'd0);
    step();
    chk("fetch_valid", 64'(fetch_valid), 64'd1);
    chk("fetch_data", 64'(fetch_data), 64'(ref_mem[widx(a)]));
  endtask

  task automatic fetch_end();
    fetch_req = 1'b0;
    step();
    chk("fetch_idle", 64'(fetch_valid), 64'd0);
  endtask

  // streams every word queued in ld_words, last one flagged
  task automatic do_load(input bit sim_fetch, input logic [31:0] faddr);
    int n;
    int exp_cnt;
    logic [31:0] w;
    n = ld_words.size();
    load_start = 1'b1;
    if (sim_fetch) begin
      fetch_req  = 1'b1;
      fetch_addr = faddr;
    end
    step();
    load_start = 1'b0;
    if (sim_fetch) begin
      chk("simul_valid", 64'(fetch_valid), 64'd1);
      chk("simul_data", 64'(fetch_data), 64'(ref_mem[widx(faddr)]));
      fetch_req = 1'b0;
    end
    chk("ld_stall", 64'(cpu_stall), 64'd1);
    chk("ld_ready", 64'(load_ready), 64'd1);
    chk("ld_cnt0", 64'(load_count), 64'd0);
    chk("ld_err0", 64'(load_err), 64'd0);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 2)) begin
        load_valid = 1'b0;
        fetch_req  = 1'($urandom_range(0, 1));
        fetch_addr = $urandom;
        @(negedge clk);
        chk("ld_idle_we", 64'(mem_we), 64'd0);
        step();
        chk("ld_nofetch", 64'(fetch_valid), 64'd0);
      end
      w = ld_words.pop_front();
      load_valid = 1'b1;
      load_data  = w;
      load_last  = (i == n - 1);
      load_start = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("ld_we", 64'(mem_we), 64'(i < DEPTH));
      if (i < DEPTH) begin
        chk("ld_addr", 64'(mem_addr), 64'(i % DEPTH));
        chk("ld_wdata", 64'(mem_wdata), 64'(w));
        ref_mem[i] = w;
      end
      step();
      load_start = 1'b0;
      exp_cnt = (i + 1 < DEPTH) ? i + 1 : DEPTH;
      chk("ld_count", 64'(load_count), 64'(exp_cnt));
      chk("ld_err", 64'(load_err), 64'(i >= DEPTH));
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
    fetch_req  = 1'b0;
    chk("done_pulse", 64'(load_done), 64'd1);
    chk("done_stall", 64'(cpu_stall), 64'd0);
    chk("done_ready", 64'(load_ready), 64'd0);
    step();
    chk("done_low", 64'(load_done), 64'd0);
    chk("err_sticky", 64'(load_err), 64'(n > DEPTH));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; fetch_req = 1'b0; fetch_addr = 32'h0; load_start = 1'b0;
    load_valid = 1'b0; load_last = 1'b0; load_data = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("rst");
    rst = 1'b0;
`ifdef IMEM_CLEAR_ON_RESET_EN
    wait_clear();
    chk("clr_stall_fall", 64'(cpu_stall), 64'd0);
    do_fetch(32'h3FC);
    fetch_end();
`else
    step();
    chk("run_stall", 64'(cpu_stall), 64'd0);
`endif

    // loader strobe in RUN is not a handshake
    load_valid = 1'b1; load_data = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("run_novalid_we", 64'(mem_we), 64'd0);
    chk("run_noready", 64'(load_ready), 64'd0);
    step();
    load_valid = 1'b0;

    ld_words = '{32'hE3A00014, 32'hE3A01A01, 32'hE0923002};
    do_load(1'b0, 32'h0);
    chk("load3_count", 64'(load_count), 64'd3);
    do_fetch(32'h0); do_fetch(32'h4); do_fetch(32'h8);
    fetch_end();
    do_fetch(32'h401);
    chk("wrap_word0", 64'(fetch_data), 64'hE3A00014);
    fetch_end();

    for (int i = 0; i < DEPTH + 1; i++) ld_words.push_back($urandom);
    do_load(1'b0, 32'h0);
    chk("ovf_count", 64'(load_count), 64'(DEPTH));
    chk("ovf_err", 64'(load_err), 64'd1);
    do_fetch(32'h0); do_fetch(32'h3FC);
    fetch_end();

    ld_words = '{32'h1234_5678, 32'h9ABC_DEF0};
    do_load(1'b0, 32'h0);

    repeat (6) begin
      for (int k = 0; k < int'($urandom_range(1, 12)); k++) ld_words.push_back($urandom);
      do_load(1'($urandom_range(0, 1)), $urandom);
      repeat (6) do_fetch($urandom);
      fetch_end();
    end

    ld_words = '{32'hCAFE_0001};
    do_load(1'b1, 32'h0000_0404);

    // reset during a 5-word load after two handshakes
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      load_valid = 1'b1; load_data = $urandom; load_last = 1'b0;
      ref_mem[i] = load_data;
      step();
    end
    load_data = $urandom;
    #2 rst = 1'b1;
    #1;
    chk_reset_vals("rst_mid");
    load_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
`ifdef IMEM_CLEAR_ON_RESET_EN
    wait_clear();
`endif
    chk("post_rst_stall", 64'(cpu_stall), 64'd0);
    do_fetch(32'h0); do_fetch(32'h4);
    fetch_end();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
